// File: rtl/microwave_timer.sv
// Microwave countdown timer: keypad MM:SS entry, one-second BCD countdown while
// the magnetron is on, and a sticky done level back to the controller.
module microwave_timer #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clearn,
  input  logic        mag_on,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  output logic [15:0] time_bcd,
  output logic        timer_done,
  output logic        sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  logic [15:0]   time_q, time_d;
  logic          done_q, done_d;
  logic          tick_q, tick_d;
  logic [PW-1:0] pre_q,  pre_d;

  logic          key_ok;
  logic          time_zero;
  logic [15:0]   time_dec;

  // Borrow chain; sec_tens may hold an entered 6..9 and simply counts down
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = t;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign key_ok    = key_valid && !mag_on && (key_digit <= 4'd9);
  assign time_zero = (time_q == 16'h0000);
  assign time_dec  = bcd_dec(time_q);

  always_comb begin
    time_d = time_q;
    done_d = done_q;
    tick_d = 1'b0;
    pre_d  = pre_q;
    if (!clearn) begin
      time_d = 16'h0000;
      done_d = 1'b0;
      pre_d  = '0;
    end else if (key_ok) begin
      time_d = {time_q[11:0], key_digit};
      done_d = 1'b0;
      pre_d  = '0;
    end else if (!mag_on) begin
      pre_d = '0;
    end else if (time_zero) begin
      done_d = 1'b1;
      pre_d  = '0;
    end else if (pre_q == PRE_MAX) begin
      pre_d  = '0;
      tick_d = 1'b1;
      time_d = time_dec;
      if (time_dec == 16'h0000) done_d = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      time_q <= 16'h0000;
      done_q <= 1'b0;
      tick_q <= 1'b0;
      pre_q  <= '0;
    end else begin
      time_q <= time_d;
      done_q <= done_d;
      tick_q <= tick_d;
      pre_q  <= pre_d;
    end
  end

  assign time_bcd   = time_q;
  assign timer_done = done_q;
  assign sec_tick   = tick_q;

endmodule

// File: doc/microwave_timer.md
# microwave_timer

Countdown timer stage for the microwave controller. It sits directly beside `control`: it takes the operator's keypad digits and the `mag_on` output of `control`, counts the loaded MM:SS time down once per second while the magnetron is on, and drives the `timer_done` input back into `control`. It also drives the BCD time value consumed by the display stage.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per one-second decrement; legal range 2 to 2^26.

Ports:
- `clk`  input  1: single system clock, rising edge.
- `resetn`  input  1: asynchronous, active-low reset.
- `clearn`  input  1: active-low clear, sampled synchronously (same signal that feeds `control`).
- `mag_on`  input  1: magnetron enable from `control`; counting occurs only while high.
- `key_valid`  input  1: one-cycle strobe, keypad digit present.
- `key_digit`  input  4: keypad digit value; values 10–15 are ignored.
- `time_bcd`  output  16: {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each, BCD.
- `timer_done`  output  1: level, countdown reached 00:00 while `mag_on` was high.
- `sec_tick`  output  1: one-cycle pulse on every decrement.

## Operation

- Reset (`resetn` low, asynchronous): `time_bcd`=16'h0000, `timer_done`=0, `sec_tick`=0, prescaler=0.
- Per-edge priority: `clearn` low > key entry > countdown.
- Clear (`clearn`=0): `time_bcd`←0, `timer_done`←0, prescaler←0. This applies regardless of `mag_on`.
- Key entry: accepted only when `key_valid`=1, `mag_on`=0, and `key_digit`≤9.
  - Shift left one digit: `time_bcd` ← {`time_bcd`[11:0], `key_digit`}. The old min_tens digit is discarded.
  - Accepted entry clears `timer_done`.
  - Entry with `mag_on`=1 or `key_digit`>9 is ignored and leaves no state change.
- Prescaler: counts 0..`TICKS_PER_SEC`-1 while `mag_on`=1 and `time_bcd`≠0. It is held at 0 whenever `mag_on`=0. A pause therefore discards the partial second.
- Decrement on prescaler wrap (`sec_tick`=1 that cycle). Borrow chain:
  - sec_ones>0: sec_ones−1.
  - Else sec_ones←9; then if sec_tens>0, sec_tens−1.
  - Else sec_tens←5; then if min_ones>0, min_ones−1.
  - Else min_ones←9, min_tens−1.
  - Entered sec_tens 6–9 is legal. Example: 01:99 counts 99 s down to 01:00, then 00:59.
- `timer_done` sets when a decrement produces 0000, or on any edge with `mag_on`=1 and `time_bcd`=0 (start with an empty timer).
- `timer_done` holds until a clear, an accepted key, or reset.
- `time_bcd`=0 never decrements or wraps.

## Timing

- All outputs are registered. No combinational path from input to output.
- Key entry latency: `time_bcd` updates on the edge that samples `key_valid`.
- First decrement: `TICKS_PER_SEC` cycles after `mag_on` is first sampled high.
- Subsequent decrements: every `TICKS_PER_SEC` cycles while `mag_on` stays high.
- Final decrement: `time_bcd`=0, `sec_tick`=1 and `timer_done`=1 all appear in the same cycle.
- Empty start: `timer_done`=1 one edge after `mag_on` is sampled high with `time_bcd`=0.
- `mag_on` falling with the prescaler at `TICKS_PER_SEC`-1: no decrement; the prescaler returns to 0.
- Simultaneous events:
  - `clearn`=0 with a wrap: clear wins, no `sec_tick`.
  - `key_valid` with `mag_on`=1: the key is dropped.
- Reset asserted mid-count: outputs go to reset values immediately (asynchronous). Counting resumes only after a new entry and `mag_on`.

## Test plan

All scenarios use `TICKS_PER_SEC`=4.

- Reset, then keys 1,3,0 -> `time_bcd`=16'h0130; `timer_done`=0; `sec_tick` never pulses.
- Keys 1,2,3,4,5 -> 16'h2345 (first digit shifted out). Then key 11 -> still 16'h2345.
- Load 00:02, hold `mag_on`=1:
  - `sec_tick` at cycles 4 and 8.
  - `time_bcd` goes 0002→0001→0000.
  - `timer_done`=1 in the same cycle as 0000 and stays high after `mag_on` drops.
- Load 01:00, run 1 s -> 16'h0059. Load 01:99, run 1 s -> 16'h0198. Load 10:00, run 1 s -> 16'h0959.
- Pause/resume and mid-run inputs, with 00:05 loaded:
  - `mag_on` high 6 cycles -> 0004.
  - Drop `mag_on` 3 cycles -> prescaler back to 0.
  - Raise again -> next decrement 4 cycles later.
  - Key pressed while running -> ignored.
  - `clearn`=0 -> 0000, `timer_done`=0, then `timer_done`=1 on the next edge (`mag_on` still 1).
- Asynchronous reset asserted mid-count between edges -> outputs zero immediately. Empty start (`mag_on`=1 with 0000) -> `timer_done`=1 after one edge.
